// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row sweep, column sync/debounce,
// key encode and a single enter strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keypad_input,
  output logic       enter,
  output logic       key_held
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [3:0]      col_m, col_s, cap_col, col_n;
  logic [1:0]      row_idx;
  logic            one_low, rotate, capture, latch_code;

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      default: col_index = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:  key_code = 4'd1;
      4'd1:  key_code = 4'd2;
      4'd2:  key_code = 4'd3;
      4'd3:  key_code = 4'd10;
      4'd4:  key_code = 4'd4;
      4'd5:  key_code = 4'd5;
      4'd6:  key_code = 4'd6;
      4'd7:  key_code = 4'd11;
      4'd8:  key_code = 4'd7;
      4'd9:  key_code = 4'd8;
      4'd10: key_code = 4'd9;
      4'd11: key_code = 4'd12;
      4'd12: key_code = 4'd14;
      4'd13: key_code = 4'd0;
      4'd14: key_code = 4'd15;
      default: key_code = 4'd13;
    endcase
  endfunction

  // Two-flop synchronizer; idle (released) level is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  // Exactly one column low; two or more lows on a row are treated as ghosting.
  assign col_n   = ~col_s;
  assign one_low = (col_n != 4'h0) && ((col_n & (col_n - 4'd1)) == 4'h0);

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt + CW'(1);
    rotate     = 1'b0;
    capture    = 1'b0;
    latch_code = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          nxt_cnt = '0;
          if (one_low) begin
            capture   = 1'b1;
            nxt_state = DEBOUNCE;
          end else begin
            rotate = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != cap_col) begin
          nxt_state = SCAN;
          nxt_cnt   = '0;
          rotate    = 1'b1;
        end else if (cnt == DB_LAST) begin
          nxt_state  = EMIT;
          nxt_cnt    = '0;
          latch_code = 1'b1;
        end
      end
      EMIT: begin
        nxt_state = RELEASE;
        nxt_cnt   = '0;
      end
      RELEASE: begin
        if (col_s != 4'hF) begin
          nxt_cnt = '0;
        end else if (cnt == DB_LAST) begin
          nxt_state = SCAN;
          nxt_cnt   = '0;
          rotate    = 1'b1;
        end
      end
      default: begin
        nxt_state = SCAN;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SCAN;
      cnt          <= '0;
      row_idx      <= 2'd0;
      cap_col      <= 4'hF;
      keypad_input <= 4'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (rotate)     row_idx      <= row_idx + 2'd1;
      if (capture)    cap_col      <= col_s;
      // Code lands together with the EMIT state so it is valid alongside enter.
      if (latch_code) keypad_input <= key_code(row_idx, col_index(cap_col));
    end
  end

  assign row_out  = ~(4'b0001 << row_idx);
  assign enter    = (state == EMIT);
  assign key_held = (state == EMIT) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driven by row_out, strobe
// codes checked against a queue of expected codes.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 16;
  localparam int DB       = 64;
  localparam int MAX_LAT  = 2 + SCAN_DIV + DB + 1;

  logic       clk;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] keypad_input;
  logic       enter;
  logic       key_held;

  logic [3:0][3:0] pressed;
  logic [3:0]      exp_q[$];
  int              checks, failures, strobe_cnt;
  logic            prev_enter, held_seen;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .keypad_input(keypad_input), .enter(enter), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (reset) begin
      if (key_held) held_seen = 1'b1;
      if (enter) begin
        strobe_cnt++;
        checks++;
        if (prev_enter !== 1'b0) begin
          failures++;
          $display("FAIL enter_consecutive: enter high two cycles in a row");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: code=%0d, no strobe expected", keypad_input);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (keypad_input !== e) begin
            failures++;
            $display("FAIL strobe_code: got %0d expected %0d", keypad_input, e);
          end
        end
      end
      prev_enter = enter;
    end else begin
      prev_enter = 1'b0;
    end
  end

  task automatic wait_strobe(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (strobe_cnt < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (strobe_cnt < target) begin
      failures++;
      $display("FAIL %s: strobe count %0d, wanted %0d within %0d cycles", name, strobe_cnt, target, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (key_held !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL %s: key_held still %b after %0d cycles", name, key_held, bound);
    end
  endtask

  task automatic wait_row_start(input logic [3:0] row);
    int n;
    n = 0;
    @(negedge clk);
    while (row_out == row && n < 200) begin @(negedge clk); n++; end
    while (row_out != row && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (row_out !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b expected 1110", row_out); end
    if (keypad_input !== 4'd0) begin failures++; $display("FAIL reset_code: got %0d expected 0", keypad_input); end
    if (enter !== 1'b0) begin failures++; $display("FAIL reset_enter: got %b expected 0", enter); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", key_held); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_press_4();
    int lat, base;
    base = strobe_cnt;
    wait_row_start(4'b1101);
    exp_q.push_back(4'd4);
    pressed[1][0] = 1'b1;
    lat = 0;
    while (enter !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    checks++;
    if (enter !== 1'b1 || lat > MAX_LAT) begin
      failures++;
      $display("FAIL press4_latency: got %0d cycles, limit %0d", lat, MAX_LAT);
    end
    repeat (500 - lat) @(negedge clk);
    checks += 2;
    if (key_held !== 1'b1) begin failures++; $display("FAIL press4_held: got %b expected 1", key_held); end
    if (strobe_cnt !== base + 1) begin failures++; $display("FAIL press4_count: got %0d expected %0d", strobe_cnt - base, 1); end
    pressed[1][0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (key_held !== 1'b1) begin failures++; $display("FAIL press4_held_release: got %b expected 1", key_held); end
    wait_idle(200, "press4_release");
    checks += 2;
    if (row_out !== 4'b1011) begin failures++; $display("FAIL press4_row_after: got %b expected 1011", row_out); end
    if (keypad_input !== 4'd4) begin failures++; $display("FAIL press4_code_held: got %0d expected 4", keypad_input); end
  endtask

  task automatic test_bounce_5();
    int base;
    base      = strobe_cnt;
    held_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pressed[1][1] = 1'b1;
      repeat (10) @(negedge clk);
      pressed[1][1] = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (150) @(negedge clk);
    checks += 2;
    if (strobe_cnt !== base) begin failures++; $display("FAIL bounce_strobe: got %0d strobes expected 0", strobe_cnt - base); end
    if (held_seen !== 1'b0) begin failures++; $display("FAIL bounce_held: key_held rose, expected 0"); end
  endtask

  task automatic test_sequence();
    logic [1:0] rr[4];
    logic [1:0] cc[4];
    logic [3:0] kk[4];
    int base;
    rr = '{2'd1, 2'd1, 2'd1, 2'd2};
    cc = '{2'd0, 2'd1, 2'd2, 2'd0};
    kk = '{4'd4, 4'd5, 4'd6, 4'd7};
    base = strobe_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(kk[i]);
      pressed[rr[i]][cc[i]] = 1'b1;
      wait_strobe(base + i + 1, 400, "seq_strobe");
      repeat (100) @(negedge clk);
      pressed[rr[i]][cc[i]] = 1'b0;
      wait_idle(200, "seq_release");
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL seq_pending: %0d codes never strobed", exp_q.size()); end
  endtask

  task automatic test_ghost();
    int base;
    logic [3:0] seen;
    base      = strobe_cnt;
    held_seen = 1'b0;
    seen      = 4'h0;
    pressed[0][0] = 1'b1;
    pressed[0][2] = 1'b1;
    repeat (200) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) if (row_out == ~(4'b0001 << r)) seen[r] = 1'b1;
    end
    pressed[0][0] = 1'b0;
    pressed[0][2] = 1'b0;
    checks += 3;
    if (strobe_cnt !== base) begin failures++; $display("FAIL ghost_strobe: got %0d strobes expected 0", strobe_cnt - base); end
    if (held_seen !== 1'b0) begin failures++; $display("FAIL ghost_held: key_held rose, expected 0"); end
    if (seen !== 4'hF) begin failures++; $display("FAIL ghost_rotate: rows seen %b expected 1111", seen); end
  endtask

  task automatic test_hash_then_8();
    int base;
    base = strobe_cnt;
    exp_q.push_back(4'd15);
    pressed[3][2] = 1'b1;
    wait_strobe(base + 1, 400, "hash_strobe");
    repeat (20) @(negedge clk);
    pressed[2][1] = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (strobe_cnt !== base + 1) begin failures++; $display("FAIL hash_second_key: got %0d strobes expected 1", strobe_cnt - base); end
    pressed[3][2] = 1'b0;
    pressed[2][1] = 1'b0;
    wait_idle(200, "hash_release");
    repeat (100) @(negedge clk);
    checks++;
    if (strobe_cnt !== base + 1) begin failures++; $display("FAIL hash_idle: got %0d strobes expected 1", strobe_cnt - base); end
    exp_q.push_back(4'd8);
    pressed[2][1] = 1'b1;
    wait_strobe(base + 2, 400, "eight_strobe");
    repeat (50) @(negedge clk);
    pressed[2][1] = 1'b0;
    wait_idle(200, "eight_release");
  endtask

  task automatic test_reset_mid();
    int base;
    base = strobe_cnt;
    wait_row_start(4'b1110);
    pressed[0][0] = 1'b1;
    // Scan sample at dwell end, then ~30 debounce counts.
    repeat (SCAN_DIV + 30) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (row_out !== 4'b1110) begin failures++; $display("FAIL midreset_row: got %b expected 1110", row_out); end
    if (keypad_input !== 4'd0) begin failures++; $display("FAIL midreset_code: got %0d expected 0", keypad_input); end
    if (enter !== 1'b0) begin failures++; $display("FAIL midreset_enter: got %b expected 0", enter); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL midreset_held: got %b expected 0", key_held); end
    pressed[0][0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (row_out !== 4'b1110) begin failures++; $display("FAIL midreset_restart_row: got %b expected 1110", row_out); end
    repeat (200) @(negedge clk);
    checks++;
    if (strobe_cnt !== base) begin failures++; $display("FAIL midreset_strobe: got %0d strobes expected 0", strobe_cnt - base); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    strobe_cnt = 0;
    prev_enter = 1'b0;
    held_seen  = 1'b0;
    pressed    = '0;
    reset      = 1'b0;
    test_reset();
    test_press_4();
    test_bounce_5();
    test_sequence();
    test_ghost();
    test_hash_then_8();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending: %0d expected strobes missing", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
